// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit with HI/LO registers for the EX stage.
// Results are computed at acceptance and committed after a fixed latency.
//
// state | meaning
// IDLE  | accepting requests; mthi/mtlo write immediately
// RUN   | counting down latency; pending result held, new starts ignored
module md_unit #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       md_op,
  input  logic [WIDTH-1:0] rs,
  input  logic [WIDTH-1:0] rt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] rd_data
);

  localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic {IDLE, RUN} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
  logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
  logic               done_q, done_d;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic               signed_op, rs_neg, rt_neg;
  logic [WIDTH-1:0]   rs_abs, rt_abs, q_mag, r_mag, div_hi, div_lo;
  logic [WIDTH-1:0]   res_hi, res_lo;

  assign prod_s = $signed({{WIDTH{rs[WIDTH-1]}}, rs}) * $signed({{WIDTH{rt[WIDTH-1]}}, rt});
  assign prod_u = {{WIDTH{1'b0}}, rs} * {{WIDTH{1'b0}}, rt};

  // Signed divide via magnitudes. The most-negative / -1 case falls out
  // naturally: |rs| / 1 negated wraps back to rs, remainder 0.
  always_comb begin
    signed_op = ~md_op[0];
    rs_neg    = signed_op & rs[WIDTH-1];
    rt_neg    = signed_op & rt[WIDTH-1];
    rs_abs    = rs_neg ? -rs : rs;
    rt_abs    = rt_neg ? -rt : rt;
    q_mag     = '0;
    r_mag     = '0;
    div_hi    = rs;
    div_lo    = '1;
    if (rt != '0) begin
      q_mag  = rs_abs / rt_abs;
      r_mag  = rs_abs % rt_abs;
      div_lo = (rs_neg ^ rt_neg) ? -q_mag : q_mag;
      div_hi = rs_neg ? -r_mag : r_mag;
    end
  end

  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (md_op[1]) begin
      res_hi = div_hi;
      res_lo = div_lo;
    end else if (md_op[0]) begin
      res_hi = prod_u[2*WIDTH-1:WIDTH];
      res_lo = prod_u[WIDTH-1:0];
    end else begin
      res_hi = prod_s[2*WIDTH-1:WIDTH];
      res_lo = prod_s[WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (!md_op[2]) begin
            pend_hi_d = res_hi;
            pend_lo_d = res_lo;
            cnt_d     = md_op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MUL_CYCLES);
            state_d   = RUN;
          end else if (md_op == 3'b110) begin
            hi_d = rs;
          end else if (md_op == 3'b111) begin
            lo_d = rs;
          end
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          hi_d    = pend_hi_q;
          lo_d    = pend_lo_q;
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy    = (state_q == RUN);
  assign done    = done_q;
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = (md_op == 3'b100) ? hi_q : lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: default instance (32-bit, 5/10 cycles) and a small
// instance (16-bit, 1/3 cycles), checked against an arithmetic model.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [2:0]  md_op = 3'b000;
  logic [31:0] rs = '0, rt = '0;

  logic        busy_a, done_a, busy_b, done_b;
  logic [31:0] hi_a, lo_a, rd_a;
  logic [15:0] hi_b, lo_b, rd_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  md_unit dut_a (
    .clk(clk), .reset(reset), .start(start_a), .md_op(md_op),
    .rs(rs), .rt(rt), .busy(busy_a), .done(done_a),
    .hi(hi_a), .lo(lo_a), .rd_data(rd_a)
  );

  md_unit #(.WIDTH(16), .MUL_CYCLES(1), .DIV_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .md_op(md_op),
    .rs(rs[15:0]), .rt(rt[15:0]), .busy(busy_b), .done(done_b),
    .hi(hi_b), .lo(lo_b), .rd_data(rd_b)
  );

  function automatic logic [31:0] get_hi(input int w);   return (w == 0) ? hi_a : {16'h0, hi_b}; endfunction
  function automatic logic [31:0] get_lo(input int w);   return (w == 0) ? lo_a : {16'h0, lo_b}; endfunction
  function automatic logic        get_busy(input int w); return (w == 0) ? busy_a : busy_b;     endfunction
  function automatic logic        get_done(input int w); return (w == 0) ? done_a : done_b;     endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Returns {hi, lo} for an arithmetic op on w-bit operands.
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                         input logic [31:0] b, input int w);
    longint unsigned mask, ua, ub, p, hv, lv;
    longint sa, sb, sq, sr, minv;
    mask = (64'd1 << w) - 64'd1;
    ua = {32'h0, a} & mask;
    ub = {32'h0, b} & mask;
    sa = longint'(ua);
    sb = longint'(ub);
    if (ua[w-1]) sa = sa - longint'(64'd1 << w);
    if (ub[w-1]) sb = sb - longint'(64'd1 << w);
    minv = -(longint'(1) << (w - 1));
    hv = 0; lv = 0;
    case (op)
      3'b000: begin p = longint'(sa * sb); hv = (p >> w) & mask; lv = p & mask; end
      3'b001: begin p = ua * ub;           hv = (p >> w) & mask; lv = p & mask; end
      default: begin
        if (ub == 0) begin
          hv = ua; lv = mask;
        end else if (op == 3'b010 && sa == minv && sb == -1) begin
          hv = 0; lv = ua;
        end else if (op == 3'b010) begin
          sq = sa / sb; sr = sa % sb;
          hv = longint'(sr) & mask; lv = longint'(sq) & mask;
        end else begin
          hv = ua % ub; lv = ua / ub;
        end
      end
    endcase
    return {hv[31:0], lv[31:0]};
  endfunction

  // Call at a negedge with the unit idle (or on its done cycle); returns on the done cycle.
  task automatic do_op(input int w, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                       input int n, input string name);
    logic [31:0] oh, ol;
    int cnt;
    oh = get_hi(w); ol = get_lo(w);
    start_a = (w == 0); start_b = (w == 1);
    md_op = op; rs = a; rt = b;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    check({name, " done_low_in_run"}, {31'h0, get_done(w)}, 32'h0);
    check({name, " hi_hold"}, get_hi(w), oh);
    check({name, " lo_hold"}, get_lo(w), ol);
    cnt = 0;
    while (get_busy(w) && cnt < 64) begin
      cnt++;
      @(negedge clk);
    end
    check({name, " busy_cycles"}, cnt, n);
    check({name, " done_pulse"}, {31'h0, get_done(w)}, 32'h1);
    check({name, " hi"}, get_hi(w), eh);
    check({name, " lo"}, get_lo(w), el);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b, eh, el;
    int          n;
    string       name;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [63:0] r;
    logic [2:0]  op;
    logic [31:0] a, b;
    int          sel, cnt;

    vecs[0] = '{3'b000, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5, "mult_neg"};
    vecs[1] = '{3'b001, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5, "multu"};
    vecs[2] = '{3'b011, 32'd100, 32'd7, 32'd2, 32'd14, 10, "divu_100_7"};
    vecs[3] = '{3'b010, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10, "div_m7_2"};
    vecs[4] = '{3'b010, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 10, "div_by0"};
    vecs[5] = '{3'b011, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 10, "divu_by0"};
    vecs[6] = '{3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000, 10, "div_ovf"};
    vecs[7] = '{3'b010, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 10, "div_7_m2"};

    repeat (2) @(negedge clk);
    check("rst busy", {31'h0, busy_a}, 32'h0);
    check("rst done", {31'h0, done_a}, 32'h0);
    check("rst hi", hi_a, 32'h0);
    check("rst lo", lo_a, 32'h0);
    check("rst rd_data", rd_a, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    foreach (vecs[i])
      do_op(0, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].eh, vecs[i].el, vecs[i].n, vecs[i].name);
    @(negedge clk);
    check("done_one_cycle", {31'h0, done_a}, 32'h0);

    // mthi / mtlo / mfhi / mflo while idle
    start_a = 1'b1; md_op = 3'b110; rs = 32'h1234;
    @(negedge clk);
    start_a = 1'b0;
    check("mthi hi", hi_a, 32'h1234);
    check("mthi busy", {31'h0, busy_a}, 32'h0);
    check("mthi done", {31'h0, done_a}, 32'h0);
    start_a = 1'b1; md_op = 3'b111; rs = 32'hCAFE0001;
    @(negedge clk);
    start_a = 1'b0;
    check("mtlo lo", lo_a, 32'hCAFE0001);
    check("mtlo hi_kept", hi_a, 32'h1234);
    md_op = 3'b100; #1;
    check("mfhi rd_data", rd_a, 32'h1234);
    md_op = 3'b101; #1;
    check("mflo rd_data", rd_a, 32'hCAFE0001);
    start_a = 1'b1; #1;
    check("mflo no_busy", {31'h0, busy_a}, 32'h0);
    @(negedge clk);
    start_a = 1'b0;
    check("mflo no_state", {31'h0, busy_a}, 32'h0);
    check("mflo hi_kept", hi_a, 32'h1234);

    // Starts injected during busy are ignored
    start_a = 1'b1; md_op = 3'b000; rs = 32'hFFFFFFFE; rt = 32'd3;
    @(negedge clk); start_a = 1'b0;                                   // busy cycle 1
    md_op = 3'b100; #1;
    check("run rd_data_old", rd_a, 32'h1234);
    @(negedge clk); start_a = 1'b1; md_op = 3'b011; rs = 32'd100; rt = 32'd7; // cycle 2
    @(negedge clk); start_a = 1'b0;                                   // cycle 3
    @(negedge clk); start_a = 1'b1; md_op = 3'b110; rs = 32'h5555;    // cycle 4
    @(negedge clk); start_a = 1'b0;                                   // cycle 5
    check("inject still_busy", {31'h0, busy_a}, 32'h1);
    @(negedge clk);
    check("inject done", {31'h0, done_a}, 32'h1);
    check("inject hi", hi_a, 32'hFFFFFFFF);
    check("inject lo", lo_a, 32'hFFFFFFFA);
    @(negedge clk);
    check("inject no_followon", {31'h0, busy_a}, 32'h0);
    check("inject hi_kept", hi_a, 32'hFFFFFFFF);

    // Reset mid-division discards the pending result
    start_a = 1'b1; md_op = 3'b010; rs = 32'd100; rt = 32'd7;
    repeat (3) @(negedge clk);
    start_a = 1'b0;
    check("rstrun busy_before", {31'h0, busy_a}, 32'h1);
    reset = 1'b1; #1;
    check("rstrun busy", {31'h0, busy_a}, 32'h0);
    check("rstrun hi", hi_a, 32'h0);
    check("rstrun lo", lo_a, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (done_a || busy_a || hi_a != 0 || lo_a != 0) cnt++;
    end
    check("rstrun no_commit", cnt, 0);

    // Small instance: 1-cycle multiply and back-to-back issue
    do_op(1, 3'b000, 32'h8000, 32'h8000, 32'h4000, 32'h0000, 1, "b_mult_min");
    r = model(3'b011, 32'h1234, 32'h0011, 16);
    do_op(1, 3'b011, 32'h1234, 32'h0011, r[63:32], r[31:0], 3, "b_b2b_divu");
    r = model(3'b010, 32'h8000, 32'hFFFF, 16);
    do_op(1, 3'b010, 32'h8000, 32'hFFFF, r[63:32], r[31:0], 3, "b_div_ovf");

    for (int w = 0; w < 2; w++) begin
      for (int k = 0; k < 40; k++) begin
        op  = 3'($urandom_range(0, 3));
        a   = $urandom;
        b   = $urandom;
        sel = $urandom_range(0, 7);
        if (sel == 0) b = 32'h0;
        else if (sel == 1) begin a = (w == 0) ? 32'h80000000 : 32'h8000; b = 32'hFFFFFFFF; end
        else if (sel == 2) begin a = $urandom_range(0, 200); b = $urandom_range(1, 9); end
        else if (sel == 3) b = -($urandom_range(1, 9));
        if (w == 1) begin a = a & 32'hFFFF; b = b & 32'hFFFF; end
        r = model(op, a, b, (w == 0) ? 32 : 16);
        do_op(w, op, a, b, r[63:32], r[31:0],
              op[1] ? ((w == 0) ? 10 : 3) : ((w == 0) ? 5 : 1),
              (w == 0) ? "rand_a" : "rand_b");
      end
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/md_unit.md
# md_unit

Parametrised multi-cycle multiply/divide unit with HI/LO registers. It sits in the EX stage beside the ALU and consumes the 3-bit multiply/divide opcode produced by EX-stage decode. It adds fixed, parametrised operation latency with a busy/done handshake for hazard stalling, plus mthi/mtlo writes. Operand width is generic.

## Interface
- WIDTH, 32, operand and HI/LO register width
- MUL_CYCLES, 5, cycles from accepted mult/multu to HI/LO commit (>=1)
- DIV_CYCLES, 10, cycles from accepted div/divu to HI/LO commit (>=1)

Ports (one clock; reset is asynchronous and active-high):
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- start  in  1  request valid this cycle
- md_op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mfhi, 101 mflo, 110 mthi, 111 mtlo
- rs  in  WIDTH  operand A (dividend / multiplicand / mthi-mtlo data)
- rt  in  WIDTH  operand B (divisor / multiplier)
- busy  out  1  operation in flight; pipeline must stall any md instruction
- done  out  1  one-cycle pulse after HI/LO commit
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register
- rd_data  out  WIDTH  md_op==100 ? hi : lo (combinational, for mfhi/mflo)

## Operation
- States: IDLE, RUN. Reset -> IDLE; hi=lo=0, busy=0, done=0, counter=0, pending result=0.
- IDLE, start=1, md_op in {000..011}: compute result from rs/rt, capture into pending_hi/pending_lo, load counter with MUL_CYCLES or DIV_CYCLES, go RUN.
- IDLE, start=1, md_op=110: hi<=rs next edge; 111: lo<=rs next edge. No busy, no done.
- md_op 100/101 with start: no state change; rd_data is purely combinational.
- RUN: decrement counter each edge. When counter==1 at an edge: hi<=pending_hi, lo<=pending_lo, done<=1, go IDLE.
- Any start while RUN, including mthi/mtlo, is ignored. The pipeline guarantees stall on busy; the unit does not queue requests.
- Multiply: full 2*WIDTH product; hi = upper WIDTH bits, lo = lower. Signed for 000, unsigned for 001.
- Divide: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend. Signed for 010, unsigned for 011.
- Divide by zero (rt==0): hi=rs, lo=all ones, for both signed and unsigned.
- Signed overflow (rs=most-negative, rt=-1, op 010): lo=rs, hi=0.
- Reset asserted in RUN: immediate return to IDLE with all state cleared. The pending result is discarded and never committed.

## Timing
- Start accepted at edge E0. busy=1 from after E0 through the cycle before commit edge E_N (N = MUL_CYCLES or DIV_CYCLES), so busy is high for exactly N cycles.
- At E_N: hi/lo updated, busy falls to 0, done rises for exactly one cycle.
- A new start is accepted on the cycle where done=1 (IDLE), giving back-to-back throughput of one operation per N+1 cycles.
- mthi/mtlo: written at the edge of acceptance; the new value is visible on hi/lo/rd_data the next cycle.
- hi/lo hold their old values throughout RUN; rd_data reflects those old values.
- busy and done are registered (glitch-free). rd_data has a combinational path from md_op, hi and lo only.

## Test plan
- Signed mult (defaults): rs=0xFFFFFFFE, rt=3, op 000 -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA, done one-cycle pulse; multu on the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- Divide: divu 100/7 -> after 10 cycles lo=14, hi=2. div rs=0xFFFFFFF9 (-7), rt=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Corner cases: div 5/0 -> hi=5, lo=0xFFFFFFFF. div 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- Handshake: issue mult, then inject start with divu and with mthi at cycles 2 and 4 of busy -> both ignored, hi/lo equal the mult result only. mthi 0x1234 issued while idle -> hi=0x1234 next cycle, busy stays 0. mflo -> rd_data=lo.
- Reset mid-operation: start div, assert reset at cycle 3 of busy -> busy=0, hi=lo=0 immediately; no done and no commit at cycle 10.
- Parameter sweep: WIDTH=16, MUL_CYCLES=1, DIV_CYCLES=3; mult 0x8000*0x8000 signed -> hi=0x4000, lo=0x0000 after 1 busy cycle; back-to-back starts on done cycles are accepted.
